// File: rtl/l1b_buyruk_onbellegi_if.sv
// Bundles the core fetch port (l1b_*) and the lower-memory read port of the
// instruction cache into one interface; the cache is the slave side.
`timescale 1ns/1ps

interface l1b_buyruk_onbellegi_if;
  logic        l1b_chip_select_n_i;
  logic [31:0] l1b_adres_i;
  logic [31:0] l1b_deger_o;
  logic        l1b_bekle_o;
  logic        onbellek_temizle_i;
  logic        bellek_istek_o;
  logic [31:0] bellek_adres_o;
  logic        bellek_hazir_i;
  logic [31:0] bellek_deger_i;

  modport slave (
    input  l1b_chip_select_n_i, l1b_adres_i, onbellek_temizle_i,
           bellek_hazir_i, bellek_deger_i,
    output l1b_deger_o, l1b_bekle_o, bellek_istek_o, bellek_adres_o
  );

  modport master (
    output l1b_chip_select_n_i, l1b_adres_i, onbellek_temizle_i,
           bellek_hazir_i, bellek_deger_i,
    input  l1b_deger_o, l1b_bekle_o, bellek_istek_o, bellek_adres_o
  );
endinterface

// File: rtl/l1b_buyruk_onbellegi.sv
// Direct-mapped, flop-based L1 instruction cache: same-cycle hits on the core
// fetch port, single-line refill over a valid/ready word-read port on a miss.
`timescale 1ns/1ps

module l1b_buyruk_onbellegi #(
  parameter int unsigned SATIR_SAYISI = 64,
  parameter int unsigned SATIR_KELIME = 4,
  parameter logic [31:0] BOS_BUYRUK   = 32'h0000_0013
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  l1b_buyruk_onbellegi_if.slave         bus
);
  localparam int unsigned IDX_W = $clog2(SATIR_SAYISI);
  localparam int unsigned WRD_W = $clog2(SATIR_KELIME);
  localparam int unsigned OFS_W = WRD_W + 2;
  localparam int unsigned TAG_W = 32 - OFS_W - IDX_W;
  localparam logic [WRD_W-1:0] SON_KELIME = WRD_W'(SATIR_KELIME - 1);

  typedef enum logic {BOSTA, DOLDUR} state_t;
  state_t state_q, state_d;

  logic [TAG_W-1:0]        tag_mem  [SATIR_SAYISI];
  logic [31:0]             data_mem [SATIR_SAYISI][SATIR_KELIME];
  logic [SATIR_SAYISI-1:0] valid_q;

  logic [31:OFS_W] base_q;    // line address of the refill in flight
  logic [WRD_W-1:0] cnt_q;
  logic             pending_q;
  logic [31:0]      adres_q;

  logic [WRD_W-1:0] fetch_word;
  logic [IDX_W-1:0] fetch_idx;
  logic [TAG_W-1:0] fetch_tag;
  logic [IDX_W-1:0] base_idx;
  logic [TAG_W-1:0] base_tag;
  logic [31:0]      refill_adres;
  logic             hit;
  logic             miss;
  logic             accept;
  logic             last;
  logic             unused_ofs;

  assign fetch_word   = bus.l1b_adres_i[OFS_W-1:2];
  assign fetch_idx    = bus.l1b_adres_i[OFS_W+IDX_W-1:OFS_W];
  assign fetch_tag    = bus.l1b_adres_i[31:OFS_W+IDX_W];
  assign base_idx     = base_q[OFS_W+IDX_W-1:OFS_W];
  assign base_tag     = base_q[31:OFS_W+IDX_W];
  assign refill_adres = {base_q, cnt_q, 2'b00};
  assign unused_ofs   = ^bus.l1b_adres_i[1:0];

  // Hits are only served while idle, so a refill never races a read of the same line.
  assign hit    = !bus.l1b_chip_select_n_i && valid_q[fetch_idx] &&
                  (tag_mem[fetch_idx] == fetch_tag) && (state_q == BOSTA);
  assign miss   = !bus.l1b_chip_select_n_i && !hit;
  assign accept = (state_q == DOLDUR) && bus.bellek_hazir_i;
  assign last   = (cnt_q == SON_KELIME);

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d            = state_q;
    bus.l1b_bekle_o    = miss;
    bus.l1b_deger_o    = BOS_BUYRUK;
    bus.bellek_istek_o = 1'b0;
    bus.bellek_adres_o = adres_q;
    if (hit) bus.l1b_deger_o = data_mem[fetch_idx][fetch_word];
    case (state_q)
      BOSTA: begin
        if (miss) state_d = DOLDUR;
      end
      DOLDUR: begin
        bus.bellek_istek_o = 1'b1;
        bus.bellek_adres_o = refill_adres;
        if (accept && last) state_d = BOSTA;
      end
      default: state_d = BOSTA;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= BOSTA;
      valid_q   <= '0;
      base_q    <= '0;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      adres_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == BOSTA) begin
        if (bus.onbellek_temizle_i) valid_q <= '0;
        if (miss) begin
          base_q <= bus.l1b_adres_i[31:OFS_W];
          cnt_q  <= '0;
        end
      end else begin
        adres_q <= refill_adres;
        if (bus.onbellek_temizle_i) pending_q <= 1'b1;
        if (accept) begin
          cnt_q <= cnt_q + 1'b1;
          if (last) begin
            // A flush seen at any point of the refill discards the new line as well.
            pending_q <= 1'b0;
            if (pending_q || bus.onbellek_temizle_i) valid_q <= '0;
            else                                     valid_q[base_idx] <= 1'b1;
          end
        end
      end
    end
  end

  // NOTE: tag/data arrays are deliberately left unreset; valid_q alone decides whether their contents are trusted.
  always_ff @(posedge clk_i) begin
    if (!rst_i && accept) begin
      data_mem[base_idx][cnt_q] <= bus.bellek_deger_i;
      if (last) tag_mem[base_idx] <= base_tag;
    end
  end
endmodule

// File: tb/tb_l1b_buyruk_onbellegi.sv
// Directed scoreboard bench for the L1 instruction cache: expected fetch data
// and refill addresses are queued at stimulus time and popped as the DUT responds.
`timescale 1ns/1ps

module tb_l1b_buyruk_onbellegi;
  localparam logic [31:0] BOS = 32'h0000_0013;
  localparam int          KELIME = 4;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   passed = 0;
  int   total  = 0;

  logic [31:0] exp_q [$];
  logic [31:0] adr_q [$];

  l1b_buyruk_onbellegi_if bus ();

  l1b_buyruk_onbellegi #(
    .SATIR_SAYISI (64),
    .SATIR_KELIME (KELIME),
    .BOS_BUYRUK   (BOS)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a >> 2) * 32'h1111_1111;
  endfunction

  assign bus.bellek_deger_i = mem_word(bus.bellek_adres_o);

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", name, obs, exp);
  endtask

  task automatic idle(input int n, input bit flush);
    bus.l1b_chip_select_n_i = 1'b1;
    for (int c = 0; c < n; c++) begin
      bus.onbellek_temizle_i = flush && (c == 0);
      @(negedge clk_i);
      check("idle_bekle", 32'(bus.l1b_bekle_o), 32'd0);
      check("idle_deger", bus.l1b_deger_o, BOS);
      @(posedge clk_i); #1;
    end
    bus.onbellek_temizle_i = 1'b0;
  endtask

  // Holds the fetch until served; slow makes the memory ready only every third cycle.
  task automatic fetch(input logic [31:0] a, input int exp_stall, input int n_refill,
                       input int flush_at, input bit slow, input string name);
    int stalls = 0;
    bit done   = 1'b0;
    bus.l1b_adres_i         = a;
    bus.l1b_chip_select_n_i = 1'b0;
    exp_q.push_back(mem_word(a));
    for (int r = 0; r < n_refill; r++)
      for (int k = 0; k < KELIME; k++)
        adr_q.push_back({a[31:4], 4'b0000} + 32'(4 * k));
    for (int c = 0; c < 200 && !done; c++) begin
      bus.onbellek_temizle_i = (c == flush_at);
      bus.bellek_hazir_i     = slow ? (c % 3 == 0) : 1'b1;
      @(negedge clk_i);
      if (bus.bellek_istek_o) begin
        if (adr_q.size() == 0) check({name, "_extra_req"}, bus.bellek_adres_o, 32'hxxxx_xxxx);
        else begin
          check({name, "_adr"}, bus.bellek_adres_o, adr_q[0]);
          if (bus.bellek_hazir_i) void'(adr_q.pop_front());
        end
      end
      if (!bus.l1b_bekle_o) begin
        check({name, "_deger"}, bus.l1b_deger_o, exp_q.pop_front());
        check({name, "_istek"}, 32'(bus.bellek_istek_o), 32'd0);
        done = 1'b1;
      end else begin
        check({name, "_stall_deger"}, bus.l1b_deger_o, BOS);
        stalls++;
      end
      @(posedge clk_i); #1;
    end
    bus.onbellek_temizle_i = 1'b0;
    bus.bellek_hazir_i     = 1'b1;
    if (!done) begin
      check({name, "_timeout"}, 32'd0, 32'd1);
      exp_q.delete();
      adr_q.delete();
    end
    check({name, "_stalls"}, 32'(stalls), 32'(exp_stall));
    check({name, "_adr_left"}, 32'(adr_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.l1b_chip_select_n_i = 1'b1;
    bus.l1b_adres_i         = '0;
    bus.onbellek_temizle_i  = 1'b0;
    bus.bellek_hazir_i      = 1'b1;
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;

    @(negedge clk_i);
    check("rst_bekle", 32'(bus.l1b_bekle_o), 32'd0);
    check("rst_deger", bus.l1b_deger_o, BOS);
    check("rst_istek", 32'(bus.bellek_istek_o), 32'd0);
    check("rst_adres", bus.bellek_adres_o, 32'd0);
    @(posedge clk_i); #1;

    // Cold miss, then zero-wait hits across the line.
    fetch(32'h0000_0000, 5, 1, -1, 1'b0, "cold0");
    fetch(32'h0000_0004, 0, 0, -1, 1'b0, "hit4");
    fetch(32'h0000_0008, 0, 0, -1, 1'b0, "hit8");
    fetch(32'h0000_000C, 0, 0, -1, 1'b0, "hitC");

    // Conflict on index 0 evicts line 0x0.
    fetch(32'h0000_0400, 5, 1, -1, 1'b0, "conf400");
    fetch(32'h0000_0000, 5, 1, -1, 1'b0, "evict0");

    // Slow memory: ready on every third cycle only.
    fetch(32'h0000_0020, 13, 1, -1, 1'b1, "slow20");
    fetch(32'h0000_0024, 0, 0, -1, 1'b0, "hit24");

    // Flush while idle, then a fetch during a flush still hits once.
    idle(2, 1'b1);
    fetch(32'h0000_0000, 5, 1, -1, 1'b0, "flush_miss0");
    fetch(32'h0000_0000, 0, 0, 0, 1'b0, "flush_same_cycle_hit");
    fetch(32'h0000_0004, 5, 1, -1, 1'b0, "after_flush_miss");

    // Flush during the second refill word: line completes, stays invalid, refetches.
    fetch(32'h0000_0020, 10, 2, 2, 1'b0, "flush_mid_refill");
    fetch(32'h0000_002C, 0, 0, -1, 1'b0, "hit2C");
    idle(1, 1'b0);

    // Reset during the second refill word.
    bus.l1b_adres_i         = 32'h0000_0040;
    bus.l1b_chip_select_n_i = 1'b0;
    @(negedge clk_i);
    check("rr_miss_bekle", 32'(bus.l1b_bekle_o), 32'd1);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check("rr_adr0", bus.bellek_adres_o, 32'h0000_0040);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(negedge clk_i);
    check("rr_adr1", bus.bellek_adres_o, 32'h0000_0044);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    bus.l1b_chip_select_n_i = 1'b1;
    @(negedge clk_i);
    check("rr_istek", 32'(bus.bellek_istek_o), 32'd0);
    check("rr_adres", bus.bellek_adres_o, 32'd0);
    check("rr_bekle", 32'(bus.l1b_bekle_o), 32'd0);
    @(posedge clk_i); #1;
    fetch(32'h0000_0000, 5, 1, -1, 1'b0, "post_reset_miss");
    fetch(32'h0000_0040, 5, 1, -1, 1'b0, "post_reset_40");

    idle(1, 1'b0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
